// File: rtl/sevenseg_scan.sv
// sevenseg_scan: multiplexed N-digit seven-segment driver with hex decode.
// One shared segment bus is time-shared across the digits by a free-running
// scan. Each slot starts with a short all-off guard window to suppress
// ghosting. Loads go into a shadow register and are committed only at a frame
// boundary, so a frame never shows a mix of old and new digits.
// Optional build macro: SEVENSEG_ZBLANK_EN enables leading-zero blanking.
module sevenseg_scan #(
  parameter int NDIGITS        = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int GUARD          = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic [NDIGITS-1:0]     blank,
  output logic                   a,
  output logic                   b,
  output logic                   c,
  output logic                   d,
  output logic                   e,
  output logic                   f,
  output logic                   g,
  output logic                   dp,
  output logic [NDIGITS-1:0]     an,
  output logic                   pending,
  output logic                   frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [PW-1:0] PCNT_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PCNT_GUARD = PW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIGITS - 1);

  // Idle ("dark") level of each output group; XOR with it applies polarity.
  localparam logic [6:0]         SEG_OFF = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic               DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NDIGITS-1:0] AN_OFF  = DIG_ACTIVE_LOW ? {NDIGITS{1'b1}} : {NDIGITS{1'b0}};

  logic [PW-1:0]          pcnt;
  logic [IW-1:0]          idx;
  logic [4*NDIGITS-1:0]   active_value, shadow_value;
  logic [NDIGITS-1:0]     active_dp, shadow_dp;
  logic [NDIGITS-1:0]     active_blank, shadow_blank;

  logic                   slot_end;
  logic                   frame_end;
  logic                   commit;
  logic [3:0]             nib [NDIGITS];
  logic [3:0]             cur_nib;
  logic                   zero_blank;
  logic [6:0]             seg_lit;
  logic                   dp_lit;
  logic [NDIGITS-1:0]     an_lit;

  assign slot_end  = (pcnt == PCNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign commit    = frame_end && pending;

  // Lit-segment pattern {a,b,c,d,e,f,g} for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0:    decode = 7'b1111110;
      4'h1:    decode = 7'b0110000;
      4'h2:    decode = 7'b1101101;
      4'h3:    decode = 7'b1111001;
      4'h4:    decode = 7'b0110011;
      4'h5:    decode = 7'b1011011;
      4'h6:    decode = 7'b1011111;
      4'h7:    decode = 7'b1110000;
      4'h8:    decode = 7'b1111111;
      4'h9:    decode = 7'b1111011;
      4'hA:    decode = 7'b1110111;
      4'hB:    decode = 7'b0011111;
      4'hC:    decode = 7'b1001110;
      4'hD:    decode = 7'b0111101;
      4'hE:    decode = 7'b1001111;
      default: decode = 7'b1000111;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_nib
      assign nib[gi] = active_value[4*gi +: 4];
    end
  endgenerate

  assign cur_nib = nib[idx];

`ifdef SEVENSEG_ZBLANK_EN
  // A digit is a leading zero when it and every digit above it are zero;
  // digit 0 always shows so a zero value still displays "0".
  logic [NDIGITS-1:0] nonzero;
  logic [NDIGITS-1:0] lead_zero;
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_zb
      assign nonzero[gi] = |nib[gi];
      if (gi == 0) begin : g_d0
        assign lead_zero[gi] = 1'b0;
      end else begin : g_dn
        assign lead_zero[gi] = ~|nonzero[NDIGITS-1:gi];
      end
    end
  endgenerate
  assign zero_blank = lead_zero[idx];
`else
  assign zero_blank = 1'b0;
`endif

  // Prescaler and digit index; frame_tick marks the wrap back to digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt       <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (slot_end) begin
        pcnt <= '0;
        idx  <= frame_end ? '0 : idx + 1'b1;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

  // Shadow/active double buffer; a load on the commit edge lands in shadow
  // after the old shadow has been committed, so it waits a further frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_value <= '0;
      active_dp    <= '0;
      active_blank <= '0;
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      pending      <= 1'b0;
    end else begin
      if (commit) begin
        active_value <= shadow_value;
        active_dp    <= shadow_dp;
        active_blank <= shadow_blank;
      end
      if (load) begin
        shadow_value <= value;
        shadow_dp    <= dp_in;
        shadow_blank <= blank;
      end
      if (load) begin
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  // Logical (polarity-free) view of what the current slot should show.
  always_comb begin
    seg_lit = 7'h00;
    dp_lit  = 1'b0;
    an_lit  = '0;
    if (pcnt >= PCNT_GUARD) begin
      for (int i = 0; i < NDIGITS; i++) begin
        an_lit[i] = (idx == IW'(i));
      end
      if (!active_blank[idx]) begin
        seg_lit = zero_blank ? 7'h00 : decode(cur_nib);
        dp_lit  = active_dp[idx];
      end
    end
  end

  // Registered pin drivers with polarity applied last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {a, b, c, d, e, f, g} <= SEG_OFF;
      dp                    <= DP_OFF;
      an                    <= AN_OFF;
    end else begin
      {a, b, c, d, e, f, g} <= seg_lit ^ SEG_OFF;
      dp                    <= dp_lit ^ DP_OFF;
      an                    <= an_lit ^ AN_OFF;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: self-checking bench for sevenseg_scan (4 digits,
// 4 cycles per slot, 1 guard cycle, active-low segments and enables).
// The reference model works from scan position and digit letters, and
// honours SEVENSEG_ZBLANK_EN when the bench is built with it.
module tb_sevenseg_scan;

  localparam int N     = 4;
  localparam int RD    = 4;
  localparam int GD    = 1;
  localparam int FRAME = N * RD;
  localparam logic [13:0] RST_VEC = 14'b1111111_1_1111_0_0;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        a, b, c, d, e, f, g, dp;
  logic [3:0]  an;
  logic        pending, frame_tick;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          cyc;
  logic [15:0] m_val, s_val;
  logic [3:0]  m_dp, s_dp, m_bl, s_bl;
  logic        m_pend;
  logic [13:0] exp_vec;

  string seg_names [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                            "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                            "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  sevenseg_scan #(
    .NDIGITS(N), .REFRESH_DIV(RD), .GUARD(GD),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .blank(blank), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .dp(dp), .an(an), .pending(pending), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Lit pattern {a..g} built from the segment letter list.
  function automatic logic [6:0] lit_of(input logic [3:0] n);
    string s;
    logic [6:0] r;
    r = '0;
    s = seg_names[n];
    for (int k = 0; k < s.len(); k++) r[6 - (int'(s[k]) - 97)] = 1'b1;
    return r;
  endfunction

  function automatic logic [13:0] obs();
    return {a, b, c, d, e, f, g, dp, an, pending, frame_tick};
  endfunction

  task automatic model_reset();
    cyc = 0;
    m_val = '0; s_val = '0; m_dp = '0; s_dp = '0; m_bl = '0; s_bl = '0;
    m_pend = 1'b0;
    exp_vec = RST_VEC;
  endtask

  // Advance one clock and compute the expected pins for the new cycle.
  task automatic step();
    int pos, dig, ph;
    logic wrap;
    logic [15:0] ov;
    logic [3:0] odp, obl, al;
    logic [6:0] sl;
    logic dl;
    pos = cyc % FRAME;
    wrap = (pos == FRAME - 1);
    ov = m_val; odp = m_dp; obl = m_bl;
    @(posedge clk);
    if (wrap && m_pend) begin
      m_val = s_val; m_dp = s_dp; m_bl = s_bl; m_pend = 1'b0;
    end
    if (load) begin
      s_val = value; s_dp = dp_in; s_bl = blank; m_pend = 1'b1;
    end
    cyc++;
    dig = pos / RD;
    ph = pos % RD;
    sl = '0; dl = 1'b0; al = '0;
    if (ph >= GD) begin
      al[dig] = 1'b1;
      if (!obl[dig]) begin
        sl = lit_of(4'((ov >> (4 * dig)) & 16'hf));
`ifdef SEVENSEG_ZBLANK_EN
        if (dig != 0 && (ov >> (4 * dig)) == 0) sl = '0;
`endif
        dl = odp[dig];
      end
    end
    exp_vec = {~sl, ~dl, ~al, m_pend, wrap};
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] bl);
    value = v; dp_in = dpv; blank = bl; load = 1'b1;
    $display("load value=%h dp=%b blank=%b at cyc=%0d", v, dpv, bl, cyc);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs() !== RST_VEC) begin
      errors++; $display("FAIL reset_pins got=%b want=%b", obs(), RST_VEC);
    end
    rst = 1'b0;
    model_reset();
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      step();
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL reset_scan cyc=%0d got=%b want=%b", cyc, obs(), exp_vec);
      end
      if (frame_tick === 1'b1) n = i;
    end
    checks++;
    if (n != 16) begin
      errors++; $display("FAIL first_tick got=%0d cycles want=16", n);
    end
  endtask

  task automatic test_load_basic();
    int i, hits;
    while (cyc % FRAME != 2) step();
    do_load(16'h1235, 4'b0000, 4'b0000);
    step();
    load = 1'b0;
    i = 0;
    do begin
      checks++;
      if (pending !== 1'b1) begin
        errors++; $display("FAIL pending_hold cyc=%0d got=%b want=1", cyc, pending);
      end
      step(); i++;
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL load_wait cyc=%0d got=%b want=%b", cyc, obs(), exp_vec);
      end
    end while (frame_tick !== 1'b1 && i < FRAME + 2);
    checks++;
    if (frame_tick !== 1'b1 || pending !== 1'b0) begin
      errors++; $display("FAIL commit_tick got tick=%b pend=%b want tick=1 pend=0", frame_tick, pending);
    end
    hits = 0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL load_show cyc=%0d got=%b want=%b", cyc, obs(), exp_vec);
      end
      if (an === 4'b1110) begin
        hits++; checks++;
        if ({a, b, c, d, e, f, g} !== 7'b0100100) begin
          errors++; $display("FAIL digit0_5 got=%b want=0100100", {a, b, c, d, e, f, g});
        end
      end
      if (an === 4'b0111) begin
        hits++; checks++;
        if ({a, b, c, d, e, f, g} !== 7'b1001111) begin
          errors++; $display("FAIL digit3_1 got=%b want=1001111", {a, b, c, d, e, f, g});
        end
      end
    end
    checks++;
    if (hits != 2 * (RD - GD)) begin
      errors++; $display("FAIL slot_hits got=%0d want=%0d", hits, 2 * (RD - GD));
    end
  endtask

  task automatic test_guard();
    int ph;
    while (cyc % FRAME != 5) step();
    do_load(16'($urandom), 4'($urandom), 4'($urandom));
    step();
    load = 1'b0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      step();
      ph = (cyc - 1) % RD;
      checks++;
      if ($countones(~an) != ((ph >= GD) ? 1 : 0)) begin
        errors++; $display("FAIL guard_an cyc=%0d got=%b want %0d low", cyc, an, (ph >= GD) ? 1 : 0);
      end
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL guard_model cyc=%0d got=%b want=%b", cyc, obs(), exp_vec);
      end
    end
  endtask

  task automatic test_back_to_back();
    while (cyc % FRAME != 5) step();
    do_load(16'hAAAA, 4'b0000, 4'b0000);
    step();
    load = 1'b0;
    for (int k = 0; k < FRAME && cyc % FRAME != FRAME - 1; k++) begin
      step();
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL b2b_wait cyc=%0d got=%b want=%b", cyc, obs(), exp_vec);
      end
    end
    do_load(16'hBEEF, 4'b0000, 4'b0000);
    step();
    load = 1'b0;
    checks++;
    if (pending !== 1'b1 || frame_tick !== 1'b1) begin
      errors++; $display("FAIL b2b_commit got pend=%b tick=%b want pend=1 tick=1", pending, frame_tick);
    end
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL b2b_show cyc=%0d got=%b want=%b", cyc, obs(), exp_vec);
      end
      if (an === 4'b1110) begin
        checks++;
        if (k < FRAME && {a, b, c, d, e, f, g} !== 7'b0001000) begin
          errors++; $display("FAIL b2b_first_A got=%b want=0001000", {a, b, c, d, e, f, g});
        end
        if (k >= FRAME && {a, b, c, d, e, f, g} !== 7'b0111000) begin
          errors++; $display("FAIL b2b_then_F got=%b want=0111000", {a, b, c, d, e, f, g});
        end
      end
    end
    checks++;
    if (pending !== 1'b0) begin
      errors++; $display("FAIL b2b_pend_clear got=%b want=0", pending);
    end
  endtask

  task automatic test_blank_dp();
    while (cyc % FRAME != 3) step();
    do_load(16'h8888, 4'b0001, 4'b0100);
    step();
    load = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL blank_model cyc=%0d got=%b want=%b", cyc, obs(), exp_vec);
      end
      if (k >= FRAME && an === 4'b1011) begin
        checks++;
        if ({a, b, c, d, e, f, g, dp} !== 8'hff) begin
          errors++; $display("FAIL blank_digit2 got=%b want=11111111", {a, b, c, d, e, f, g, dp});
        end
      end
      if (k >= FRAME && an === 4'b1110) begin
        checks++;
        if ({a, b, c, d, e, f, g, dp} !== 8'h00) begin
          errors++; $display("FAIL dp_digit0 got=%b want=00000000", {a, b, c, d, e, f, g, dp});
        end
      end
    end
  endtask

  task automatic test_zblank();
    logic [6:0] want3;
`ifdef SEVENSEG_ZBLANK_EN
    want3 = 7'b1111111;
`else
    want3 = 7'b0000001;
`endif
    while (cyc % FRAME != 3) step();
    do_load(16'h0040, 4'b0000, 4'b0000);
    step();
    load = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL zb_model cyc=%0d got=%b want=%b", cyc, obs(), exp_vec);
      end
      if (k >= FRAME && (an === 4'b0111 || an === 4'b1011)) begin
        checks++;
        if ({a, b, c, d, e, f, g} !== want3) begin
          errors++; $display("FAIL zb_lead an=%b got=%b want=%b", an, {a, b, c, d, e, f, g}, want3);
        end
      end
      if (k >= FRAME && an === 4'b1101) begin
        checks++;
        if ({a, b, c, d, e, f, g} !== 7'b1001100) begin
          errors++; $display("FAIL zb_digit1 got=%b want=1001100", {a, b, c, d, e, f, g});
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0)
        do_load(16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) & 4'($urandom)));
      step();
      load = 1'b0;
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs(), exp_vec);
      end
    end
  endtask

  task automatic test_async_reset();
    while (cyc % FRAME != 6) step();
    do_load(16'h9C3E, 4'b1010, 4'b0000);
    step();
    load = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== RST_VEC) begin
      errors++; $display("FAIL async_reset got=%b want=%b", obs(), RST_VEC);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL after_reset cyc=%0d got=%b want=%b", cyc, obs(), exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_guard();
    test_back_to_back();
    test_blank_dp();
    test_zblank();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
